// File: rtl/core_timer_multi_if.sv
// core_timer_multi_if: Avalon-MM slave bus of the multi-channel timer.
interface core_timer_multi_if #(
   parameter int NUM_CH = 4
);
   localparam int ADDR_W = $clog2(NUM_CH) + 3;
   logic              chipselect;
   logic [ADDR_W-1:0] address;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   modport master (output chipselect, address, write_n, writedata, input readdata);
   modport slave  (input chipselect, address, write_n, writedata, output readdata);
endinterface

// File: rtl/core_timer_multi.sv
// core_timer_multi: NUM_CH down-counting interval timers behind one Avalon-MM slave.
// Define CORE_TIMER_PRESCALE_EN to give each channel a 16-bit clock prescaler.
module core_timer_multi #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 32,
   parameter int RESET_PERIOD = 49999
) (
   input  logic                clk,
   input  logic                reset,
   core_timer_multi_if.slave   bus,
   output logic [NUM_CH-1:0]   irq_vec,
   output logic                irq
);
   localparam int ADDR_W = $clog2(NUM_CH) + 3;
   logic [ADDR_W-1:0] ch;
   logic [2:0]        rsel;
   logic              bus_wr;
   logic [31:0]       rd_word [NUM_CH];
   logic [31:0]       rd_next;
   assign ch     = bus.address >> 3;
   assign rsel   = bus.address[2:0];
   assign bus_wr = bus.chipselect && !bus.write_n;
   assign irq    = |irq_vec;
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             wr, st_wr, ctl_wr, per_wr, snap_wr, start, stop, fire, tick;
      logic             to, run, ito, cont, reload;
      logic [CNT_W-1:0] period, cnt, snap;
      logic [31:0]      psc_rd;
      assign wr      = bus_wr && ch == ADDR_W'(c);
      assign st_wr   = wr && rsel == 3'd0;
      assign ctl_wr  = wr && rsel == 3'd1;
      assign per_wr  = wr && rsel == 3'd2;
      assign snap_wr = wr && rsel == 3'd3;
      assign start   = ctl_wr && bus.writedata[2];
      assign stop    = ctl_wr && bus.writedata[3];
      assign fire    = run && tick && cnt == '0;
      assign irq_vec[c] = to && ito;
      assign rd_word[c] = rsel == 3'd0 ? {30'd0, run, to} :
                          rsel == 3'd1 ? {30'd0, cont, ito} :
                          rsel == 3'd2 ? 32'(period) :
                          rsel == 3'd3 ? 32'(snap) :
                          rsel == 3'd4 ? psc_rd : 32'd0;
`ifdef CORE_TIMER_PRESCALE_EN
      logic [15:0] psc, pcnt;
      assign tick   = pcnt == '0;
      assign psc_rd = {16'd0, psc};
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            psc  <= '0;
            pcnt <= '0;
         end else begin
            if (wr && rsel == 3'd4) psc <= bus.writedata[15:0];
            if (start || reload) pcnt <= '0;
            else if (run) pcnt <= tick ? psc : pcnt - 16'd1;
         end
`else
      assign tick   = 1'b1;
      assign psc_rd = '0;
`endif
      // a timeout on the same edge as a STATUS write must survive the clear
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            to     <= 1'b0;
            run    <= 1'b0;
            ito    <= 1'b0;
            cont   <= 1'b0;
            reload <= 1'b0;
            period <= CNT_W'(RESET_PERIOD);
            cnt    <= CNT_W'(RESET_PERIOD);
            snap   <= '0;
         end else begin
            to     <= fire || (to && !st_wr);
            run    <= start || (run && !stop && !per_wr && !(fire && !cont));
            reload <= per_wr;
            if (ctl_wr) {cont, ito} <= bus.writedata[1:0];
            if (per_wr) period <= bus.writedata[CNT_W-1:0];
            if (reload) cnt <= period;
            else if (run && tick) cnt <= fire ? period : cnt - CNT_W'(1);
            if (snap_wr) snap <= cnt;
         end
   end
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch == ADDR_W'(i)) rd_next = rd_word[i];
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) bus.readdata <= '0;
      else bus.readdata <= rd_next;
endmodule

// File: tb/tb_core_timer_multi.sv
// tb_core_timer_multi: directed checks of the multi-channel timer (default build plus a narrow 3-channel build).
module tb_core_timer_multi;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] irq_vec;
   logic irq;
   logic [2:0] irq_vec2;
   logic irq2;
   int checks = 0;
   int failures = 0;
   int n;
   logic [31:0] q;
   always #5 clk = ~clk;
   core_timer_multi_if #(.NUM_CH(4)) bus ();
   core_timer_multi_if #(.NUM_CH(3)) bus2 ();
   core_timer_multi #(.NUM_CH(4), .CNT_W(32), .RESET_PERIOD(49999)) dut (
      .clk(clk), .reset(reset), .bus(bus), .irq_vec(irq_vec), .irq(irq));
   core_timer_multi #(.NUM_CH(3), .CNT_W(8), .RESET_PERIOD(200)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2), .irq_vec(irq_vec2), .irq(irq2));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wr(input int s, input int c, input int r, input logic [31:0] d);
      bus.address = 5'(c * 8 + r);
      bus2.address = 5'(c * 8 + r);
      bus.writedata = d;
      bus2.writedata = d;
      bus.chipselect = (s == 0);
      bus.write_n = (s != 0);
      bus2.chipselect = (s == 1);
      bus2.write_n = (s != 1);
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
      bus2.chipselect = 1'b0;
      bus2.write_n = 1'b1;
   endtask
   task automatic rchk(input int s, input int c, input int r, input logic [31:0] exp, input string tag);
      bus.address = 5'(c * 8 + r);
      bus2.address = 5'(c * 8 + r);
      @(negedge clk);
      chk(tag, s == 0 ? bus.readdata : bus2.readdata, exp);
   endtask
   task automatic wait_irq(input int c, output int cyc);
      cyc = 0;
      while (!irq_vec[c] && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
   endtask
   initial begin
      bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;
      bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.address = '0; bus2.writedata = '0;
      repeat (3) @(negedge clk);
      chk("rst_readdata", bus.readdata, 0);
      chk("rst_irq", {31'd0, irq}, 0);
      chk("rst_irq_vec", {28'd0, irq_vec}, 0);
      reset = 1'b0;
      rchk(0, 0, 2, 49999, "rst_period");
      rchk(0, 0, 0, 0, "rst_status");
      rchk(0, 0, 3, 0, "rst_snap");
      wr(0, 0, 3, 0);
      rchk(0, 0, 3, 49999, "rst_counter");
      // ch0 continuous, period 9
      wr(0, 0, 2, 9);
      wr(0, 0, 1, 7);
      wait_irq(0, n);
      chk("ch0_first_to", n, 10);
      wr(0, 0, 3, 0);
      wr(0, 0, 0, 0);
      chk("ch0_irq_cleared", {31'd0, irq}, 0);
      wait_irq(0, n);
      chk("ch0_second_to", n, 8);
      rchk(0, 0, 3, 9, "ch0_cnt_after_to");
      rchk(0, 0, 0, 3, "ch0_status_run");
      repeat (7) @(negedge clk);
      wr(0, 0, 0, 0);
      chk("ch0_clear_vs_to_irq", {28'd0, irq_vec}, 4'b0001);
      rchk(0, 0, 0, 3, "ch0_clear_vs_to_status");
      // force reload while running
      wr(0, 0, 2, 100);
      @(negedge clk);
      wr(0, 0, 3, 0);
      rchk(0, 0, 3, 100, "ch0_reload_cnt");
      rchk(0, 0, 0, 1, "ch0_reload_stopped");
      repeat (5) @(negedge clk);
      wr(0, 0, 3, 0);
      rchk(0, 0, 3, 100, "ch0_cnt_holds");
      wr(0, 0, 0, 0);
      chk("ch0_irq_low", {31'd0, irq}, 0);
      wr(0, 0, 1, 12);
      rchk(0, 0, 0, 2, "start_stop_start_wins");
      wr(0, 0, 1, 8);
      rchk(0, 0, 0, 0, "stop");
      wr(0, 0, 5, 32'hFFFF_FFFF);
      rchk(0, 0, 5, 0, "reserved5");
      rchk(0, 0, 1, 0, "ctrl_readback");
      // ch1 one-shot
      wr(0, 1, 2, 4);
      wr(0, 1, 1, 5);
      wait_irq(1, n);
      chk("ch1_oneshot_to", n, 5);
      rchk(0, 1, 0, 1, "ch1_run_cleared");
      wr(0, 1, 3, 0);
      rchk(0, 1, 3, 4, "ch1_cnt_holds");
      repeat (20) @(negedge clk);
      chk("ch1_irq_held", {31'd0, irq}, 1);
      chk("ch1_irq_vec", {28'd0, irq_vec}, 4'b0010);
      rchk(0, 1, 0, 1, "ch1_single_to");
      wr(0, 1, 0, 0);
      chk("ch1_irq_cleared", {31'd0, irq}, 0);
      // ch2 with prescale 2
      wr(0, 2, 4, 2);
`ifdef CORE_TIMER_PRESCALE_EN
      rchk(0, 2, 4, 2, "ch2_prescale_rd");
`else
      rchk(0, 2, 4, 0, "ch2_prescale_rd");
`endif
      wr(0, 2, 2, 3);
      wr(0, 2, 1, 7);
      wait_irq(2, n);
`ifdef CORE_TIMER_PRESCALE_EN
      chk("ch2_first_to", n, 10);
`else
      chk("ch2_first_to", n, 4);
`endif
      wr(0, 2, 0, 0);
      wait_irq(2, n);
`ifdef CORE_TIMER_PRESCALE_EN
      chk("ch2_interval", n, 11);
`else
      chk("ch2_interval", n, 3);
`endif
      wr(0, 2, 1, 8);
      wr(0, 2, 0, 0);
      chk("ch2_irq_cleared", {31'd0, irq}, 0);
      // ch3 snapshot while counting
      wr(0, 3, 2, 1000);
      wr(0, 3, 1, 4);
      repeat (10) @(negedge clk);
      wr(0, 3, 3, 0);
      rchk(0, 3, 3, 990, "ch3_snap1");
      wr(0, 3, 3, 0);
      rchk(0, 3, 3, 988, "ch3_snap2");
      // asynchronous reset mid-count
      reset = 1'b1;
      #1;
      chk("mid_rst_readdata", bus.readdata, 0);
      chk("mid_rst_irq_vec", {28'd0, irq_vec}, 0);
      @(negedge clk);
      reset = 1'b0;
      rchk(0, 3, 0, 0, "post_rst_status");
      rchk(0, 3, 2, 49999, "post_rst_period");
      repeat (5) @(negedge clk);
      wr(0, 3, 3, 0);
      rchk(0, 3, 3, 49999, "post_rst_cnt_idle");
      // narrow build: 3 channels, 8-bit counters
      rchk(1, 1, 2, 200, "d2_reset_period");
      wr(1, 0, 2, 32'h1FF);
      rchk(1, 0, 2, 32'hFF, "d2_period_trunc");
      wr(1, 3, 2, 5);
      rchk(1, 3, 2, 0, "d2_oor_read");
      rchk(1, 1, 2, 200, "d2_ch1_untouched");
      rchk(1, 2, 2, 200, "d2_ch2_untouched");
      wr(1, 3, 1, 7);
      repeat (5) @(negedge clk);
      chk("d2_oor_no_irq", {29'd0, irq_vec2}, 0);
      rchk(1, 0, 0, 0, "d2_ch0_idle");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
